// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the WISC pipeline sequencing controller.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters).
package pipe_ctrl_pkg;

    // Controller state: normal issue, draining after HLT, and halted.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    // Dominant cause of a Decode stall, for debug visibility.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LOAD_USE = 2'd1,
        BR_REG   = 2'd2,
        FLAG     = 2'd3
    } stall_reason_t;

    // R0 is hard-wired to zero, so it never creates a dependency.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the WISC pipeline registers and the sequencing controller.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cnt/flush_cnt counters.
// Directions: the pipeline (master) drives Decode/EX/MEM/WB attributes; the
// controller (slave) drives stall, bubble, flush and halted back. Every output
// is a level signal that holds for the cycle it is asserted in; there is no
// valid/ready exchange on this bundle.
interface pipeline_ctrl_if #(
    parameter int REG_W = 4
`ifdef PIPE_CTRL_PERF_EN
    , parameter int CNT_W = 16
`endif
);
    logic [REG_W-1:0] ID_SrcReg1;
    logic [REG_W-1:0] ID_SrcReg2;
    logic             ID_uses_rs1;
    logic             ID_uses_rs2;
    logic             ID_is_branch;
    logic             ID_is_BR;
    logic             ID_HLT;
    logic             ID_update_PC;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MemRead;
    logic             ID_EX_flag_en;
    logic [REG_W-1:0] ID_EX_reg_rd;
    logic             EX_MEM_RegWrite;
    logic             EX_MEM_MemRead;
    logic [REG_W-1:0] EX_MEM_reg_rd;
    logic             MEM_WB_HLT;
    logic             PC_stall;
    logic             IF_ID_stall;
    logic             ID_EX_bubble;
    logic             IF_ID_flush;
    logic             halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport master (
`ifdef PIPE_CTRL_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        output ID_SrcReg1, ID_SrcReg2, ID_uses_rs1, ID_uses_rs2,
        output ID_is_branch, ID_is_BR, ID_HLT, ID_update_PC,
        output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_flag_en, ID_EX_reg_rd,
        output EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_reg_rd, MEM_WB_HLT,
        input  PC_stall, IF_ID_stall, ID_EX_bubble, IF_ID_flush, halted
    );

    modport slave (
`ifdef PIPE_CTRL_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        input  ID_SrcReg1, ID_SrcReg2, ID_uses_rs1, ID_uses_rs2,
        input  ID_is_branch, ID_is_BR, ID_HLT, ID_update_PC,
        input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_flag_en, ID_EX_reg_rd,
        input  EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_reg_rd, MEM_WB_HLT,
        output PC_stall, IF_ID_stall, ID_EX_bubble, IF_ID_flush, halted
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational Decode-stage hazard detection: load-use, register-branch
// source dependency and flag dependency of conditional branches.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] ID_SrcReg1,
    input  logic [REG_W-1:0] ID_SrcReg2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_is_branch,
    input  logic             ID_is_BR,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_flag_en,
    input  logic [REG_W-1:0] ID_EX_reg_rd,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_reg_rd,
    output logic             load_use,
    output logic             br_reg,
    output logic             flag_dep,
    output logic             stall,
    output stall_reason_t    reason
);
    localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

    logic ex_rd_live;
    logic mem_rd_live;

    assign ex_rd_live  = (ID_EX_reg_rd != ZERO);
    assign mem_rd_live = (EX_MEM_reg_rd != ZERO);

    // Hazard terms and the dominant stall reason (load-use first, then BR, then flags).
    always_comb begin
        load_use = ID_EX_MemRead & ID_EX_RegWrite & ex_rd_live &
                   ((ID_uses_rs1 & (ID_SrcReg1 == ID_EX_reg_rd)) |
                    (ID_uses_rs2 & (ID_SrcReg2 == ID_EX_reg_rd)));
        br_reg   = ID_is_branch & ID_is_BR &
                   ((ID_EX_RegWrite & ex_rd_live & (ID_SrcReg1 == ID_EX_reg_rd)) |
                    (EX_MEM_MemRead & mem_rd_live & (ID_SrcReg1 == EX_MEM_reg_rd)));
        flag_dep = ID_is_branch & ~ID_is_BR & ID_EX_flag_en;
        stall    = load_use | br_reg | flag_dep;
        reason   = NONE;
        if (load_use)      reason = LOAD_USE;
        else if (br_reg)   reason = BR_REG;
        else if (flag_dep) reason = FLAG;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// WISC pipeline sequencing controller: stall/bubble/flush generation and the
// HLT drain state machine. Optional feature macro: PIPE_CTRL_PERF_EN adds
// saturating stall and misprediction-flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 4
`ifdef PIPE_CTRL_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus,
    output ctrl_state_t    state_dbg,
    output stall_reason_t  stall_reason_dbg
);
    ctrl_state_t state_q, state_d;
    logic        halted_q;
    logic        load_use, br_reg, flag_dep, stall;
    logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ID_SrcReg1     (bus.ID_SrcReg1),
        .ID_SrcReg2     (bus.ID_SrcReg2),
        .ID_uses_rs1    (bus.ID_uses_rs1),
        .ID_uses_rs2    (bus.ID_uses_rs2),
        .ID_is_branch   (bus.ID_is_branch),
        .ID_is_BR       (bus.ID_is_BR),
        .ID_EX_RegWrite (bus.ID_EX_RegWrite),
        .ID_EX_MemRead  (bus.ID_EX_MemRead),
        .ID_EX_flag_en  (bus.ID_EX_flag_en),
        .ID_EX_reg_rd   (bus.ID_EX_reg_rd),
        .EX_MEM_MemRead (bus.EX_MEM_MemRead),
        .EX_MEM_reg_rd  (bus.EX_MEM_reg_rd),
        .load_use       (load_use),
        .br_reg         (br_reg),
        .flag_dep       (flag_dep),
        .stall          (stall),
        .reason         (stall_reason_dbg)
    );

    // Next state and control outputs; reset forces every control output low.
    always_comb begin
        state_d      = state_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (stall) begin
                        // Mispredict and HLT wait until the hazard clears.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        if (bus.ID_update_PC) if_id_flush = 1'b1;
                        if (bus.ID_HLT) begin
                            // HLT moves on into ID/EX; nothing behind it is fetched.
                            pc_stall    = 1'b1;
                            if_id_flush = 1'b1;
                            state_d     = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    if (bus.MEM_WB_HLT) state_d = HALTED;
                end
                HALTED: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register and sticky halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_q | (state_d == HALTED);
        end
    end

    assign bus.PC_stall     = pc_stall;
    assign bus.IF_ID_stall  = if_id_stall;
    assign bus.ID_EX_bubble = id_ex_bubble;
    assign bus.IF_ID_flush  = if_id_flush;
    assign bus.halted       = halted_q;
    assign state_dbg        = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters, live only while issuing in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q == RUN) begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (!stall && bus.ID_update_PC && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a hazard vector table plus hand-written
// multi-cycle sequences for stall lengths, mispredict, halt drain and reset.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int REG_W = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam int CNT_W = 16;
`endif

    logic          clk;
    logic          rst;
    ctrl_state_t   state_dbg;
    stall_reason_t stall_reason_dbg;

    int tests_run = 0;
    int fails     = 0;
    int exp_stall_cnt = 0;
    int exp_flush_cnt = 0;

`ifdef PIPE_CTRL_PERF_EN
    pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
    pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
`else
    pipeline_ctrl_if #(.REG_W(REG_W)) bus ();
    pipeline_ctrl #(.REG_W(REG_W)) dut (
`endif
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .state_dbg        (state_dbg),
        .stall_reason_dbg (stall_reason_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector record: decode/EX/MEM inputs and expected {PC_stall, IF_ID_stall, ID_EX_bubble, IF_ID_flush}.
    typedef struct {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1, u2, br, is_br, upd;
        logic       ex_rw, ex_mr, ex_fe;
        logic [3:0] ex_rd;
        logic       mem_rw, mem_mr;
        logic [3:0] mem_rd;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ID_SrcReg1 = '0;     bus.ID_SrcReg2 = '0;
        bus.ID_uses_rs1 = 1'b0;  bus.ID_uses_rs2 = 1'b0;
        bus.ID_is_branch = 1'b0; bus.ID_is_BR = 1'b0;
        bus.ID_HLT = 1'b0;       bus.ID_update_PC = 1'b0;
        bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_MemRead = 1'b0;
        bus.ID_EX_flag_en = 1'b0;  bus.ID_EX_reg_rd = '0;
        bus.EX_MEM_RegWrite = 1'b0; bus.EX_MEM_MemRead = 1'b0;
        bus.EX_MEM_reg_rd = '0;  bus.MEM_WB_HLT = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        clear_inputs();
        bus.ID_SrcReg1 = v.rs1;    bus.ID_SrcReg2 = v.rs2;
        bus.ID_uses_rs1 = v.u1;    bus.ID_uses_rs2 = v.u2;
        bus.ID_is_branch = v.br;   bus.ID_is_BR = v.is_br;
        bus.ID_update_PC = v.upd;
        bus.ID_EX_RegWrite = v.ex_rw; bus.ID_EX_MemRead = v.ex_mr;
        bus.ID_EX_flag_en = v.ex_fe;  bus.ID_EX_reg_rd = v.ex_rd;
        bus.EX_MEM_RegWrite = v.mem_rw; bus.EX_MEM_MemRead = v.mem_mr;
        bus.EX_MEM_reg_rd = v.mem_rd;
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs on the falling edge and compare.
    task automatic check_outs(input string name, input logic [3:0] exp);
        @(negedge clk);
        check(name, 32'({bus.PC_stall, bus.IF_ID_stall, bus.ID_EX_bubble, bus.IF_ID_flush}), 32'(exp));
    endtask

    // Expected counter model for RUN cycles without HLT.
    task automatic tally(input logic [3:0] exp);
        if (exp[1]) exp_stall_cnt++;
        if (exp[0] && !exp[1]) exp_flush_cnt++;
    endtask

    task automatic check_counters(input string name);
`ifdef PIPE_CTRL_PERF_EN
        check({name, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall_cnt));
        check({name, "_flush_cnt"}, 32'(bus.flush_cnt), 32'(exp_flush_cnt));
`else
        check({name, "_no_perf_halted"}, 32'(bus.halted), 32'(state_dbg == HALTED));
`endif
    endtask

    // Run one RUN-state cycle: drive, check, and update the counter model.
    task automatic run_vec(input string name, input vec_t v);
        next_cycle();
        drive_vec(v);
        check_outs(name, v.exp);
        tally(v.exp);
    endtask

    initial begin
        vec_t v;
        //          rs1   rs2   u1 u2 br isbr upd exrw exmr exfe exrd  mrw  mmr  mrd   exp
        vecs[0]  = '{4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0000};
        vecs[1]  = '{4'd1, 4'd5, 1, 1, 0, 0, 0, 1, 1, 0, 4'd5, 0, 0, 4'd0, 4'b1110};
        vecs[2]  = '{4'd1, 4'd0, 1, 1, 0, 0, 0, 1, 1, 0, 4'd0, 0, 0, 4'd0, 4'b0000};
        vecs[3]  = '{4'd5, 4'd2, 0, 1, 0, 0, 0, 1, 1, 0, 4'd5, 0, 0, 4'd0, 4'b0000};
        vecs[4]  = '{4'd1, 4'd5, 1, 1, 0, 0, 0, 1, 0, 0, 4'd5, 0, 0, 4'd0, 4'b0000};
        vecs[5]  = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 1, 0, 0, 4'd3, 0, 0, 4'd0, 4'b1110};
        vecs[6]  = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 1, 4'd3, 4'b1110};
        vecs[7]  = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 4'd3, 4'b0000};
        vecs[8]  = '{4'd0, 4'd0, 0, 0, 1, 0, 0, 0, 0, 1, 4'd0, 0, 0, 4'd0, 4'b1110};
        vecs[9]  = '{4'd0, 4'd0, 0, 0, 1, 0, 0, 1, 0, 0, 4'd7, 0, 0, 4'd0, 4'b0000};
        vecs[10] = '{4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0001};
        vecs[11] = '{4'd6, 4'd0, 1, 0, 0, 0, 1, 1, 1, 0, 4'd6, 0, 0, 4'd0, 4'b1110};
        vecs[12] = '{4'd0, 4'd0, 1, 0, 1, 1, 0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 4'b0000};
        vecs[13] = '{4'd2, 4'd4, 1, 1, 0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 4'd0, 4'b0000};
        vecs[14] = '{4'd2, 4'd0, 1, 0, 1, 1, 0, 0, 0, 1, 4'd9, 0, 0, 4'd0, 4'b0000};

        // Reset phase
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        bus.ID_HLT = 1'b1;
        bus.ID_update_PC = 1'b1;
        check_outs("reset_outputs_low", 4'b0000);
        next_cycle();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(state_dbg), 32'(RUN));
        check("reset_halted", 32'(bus.halted), 32'd0);
        check_counters("reset");

        // Combinational hazard table in RUN
        for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
        check_counters("table");

        // Load-use lasts one cycle: the load moves to MEM and the bubble sits in EX.
        v = '{4'd0, 4'd5, 0, 1, 0, 0, 0, 1, 1, 0, 4'd5, 0, 0, 4'd0, 4'b1110};
        run_vec("lu_c1", v);
        v = '{4'd0, 4'd5, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1, 4'd5, 4'b0000};
        run_vec("lu_c2", v);

        // BR on ALU producer: one stall cycle.
        v = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 1, 0, 0, 4'd3, 0, 0, 4'd0, 4'b1110};
        run_vec("br_alu_c1", v);
        v = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 4'd3, 4'b0000};
        run_vec("br_alu_c2", v);

        // BR on load producer: two stall cycles (EX then MEM).
        v = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 1, 1, 0, 4'd3, 0, 0, 4'd0, 4'b1110};
        run_vec("br_ld_c1", v);
        v = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 1, 4'd3, 4'b1110};
        run_vec("br_ld_c2", v);
        v = '{4'd3, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0000};
        run_vec("br_ld_c3", v);

        // Flag dependency hides a mispredict for one cycle, then the flush goes out.
        v = '{4'd0, 4'd0, 0, 0, 1, 0, 1, 0, 0, 1, 4'd0, 0, 0, 4'd0, 4'b1110};
        run_vec("flag_upd_c1", v);
        v = '{4'd0, 4'd0, 0, 0, 1, 0, 1, 0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0001};
        run_vec("flag_upd_c2", v);
        check_counters("seq");

        // Halt entry and drain
        next_cycle();
        clear_inputs();
        bus.ID_HLT = 1'b1;
        check_outs("hlt_entry", 4'b1001);
        next_cycle();
        clear_inputs();
        v = '{4'd0, 4'd5, 0, 1, 0, 0, 1, 1, 1, 0, 4'd5, 0, 0, 4'd0, 4'b1001};
        drive_vec(v);
        check_outs("drain_ignores_hazard", 4'b1001);
        check("drain_state", 32'(state_dbg), 32'(DRAIN));
        next_cycle();
        clear_inputs();
        check_outs("drain_c2", 4'b1001);
        next_cycle();
        bus.MEM_WB_HLT = 1'b1;
        check_outs("drain_c3", 4'b1001);
        check("halted_before_retire", 32'(bus.halted), 32'd0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("halted_rise", 32'(bus.halted), 32'd1);
        check("halted_state", 32'(state_dbg), 32'(HALTED));
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            bus.ID_update_PC = i[0];
            check_outs($sformatf("halted_outs%0d", i), 4'b1001);
            check($sformatf("halted_hold%0d", i), 32'(bus.halted), 32'd1);
        end
        check_counters("frozen");

        // Reset out of HALTED
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        check_outs("rst_halted_outs", 4'b0000);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_halted", 32'(bus.halted), 32'd0);
        check("post_rst_state", 32'(state_dbg), 32'(RUN));
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
        check_counters("post_rst");

        // Reset one cycle into DRAIN
        next_cycle();
        bus.ID_HLT = 1'b1;
        check_outs("hlt_entry2", 4'b1001);
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        check_outs("rst_mid_drain_outs", 4'b0000);
        next_cycle();
        rst = 1'b0;
        check_outs("after_mid_drain_idle", 4'b0000);
        check("after_mid_drain_state", 32'(state_dbg), 32'(RUN));
        run_vec("after_mid_drain_lu", vecs[1]);
        check_counters("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
